// File: rtl/fifo_byte_streamer_pkg.sv
// Shared types and sizing helpers for the FIFO-to-byte-stream read engine.
// The CSUM state exists only when FIFO_BYTE_STREAMER_CHECKSUM_EN is defined.
package fifo_byte_streamer_pkg;

    localparam int WORD_COUNT_W = 16;

`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_SEND,
        ST_CSUM
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_LOAD,
        ST_SEND
    } state_t;
`endif

    function automatic int bytes_per_word(input int width);
        return width / 8;
    endfunction

    // A single-byte word still needs a 1-bit index to keep the port legal.
    function automatic int idx_width(input int width);
        return ((width / 8) > 1) ? $clog2(width / 8) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_streamer_shifter.sv
// Word load/shift register with byte index; presents the MSB byte and flags the last byte.
// Load and shift are mutually exclusive strobes from the controlling FSM.
module fifo_byte_streamer_shifter
    import fifo_byte_streamer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             shift_i,
    output logic [7:0]       byte_o,
    output logic             last_o
);

    localparam int BPW = bytes_per_word(WIDTH);
    localparam int IW  = idx_width(WIDTH);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [IW-1:0]    idx_q, idx_d;

    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        if (load_i) begin
            sh_d  = data_i;
            idx_d = '0;
        end else if (shift_i) begin
            sh_d  = sh_q << 8;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end

    assign byte_o = sh_q[WIDTH-1 -: 8];
    assign last_o = (idx_q == IW'(BPW - 1));

endmodule

// File: rtl/fifo_byte_streamer.sv
// Pops FIFO words and streams them MSB byte first over valid/ready; owns the FIFO read strobes.
// Optional per-frame XOR checksum byte under macro FIFO_BYTE_STREAMER_CHECKSUM_EN.
module fifo_byte_streamer
    import fifo_byte_streamer_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int FRAME_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    fifo_empty,
    input  logic [WIDTH-1:0]        fifo_data,
    output logic                    fifo_rd_cs,
    output logic                    fifo_rd_en,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic                    busy,
    output logic [WORD_COUNT_W-1:0] word_count
);

    state_t                  state_q, state_d;
    logic [WORD_COUNT_W-1:0] wc_q, wc_d;

    logic [7:0] sh_byte;
    logic       sh_last;
    logic       send_xfer;
    logic       last_xfer;
    logic       next_word;
    logic       frame_done;

    assign send_xfer = (state_q == ST_SEND) && tx_ready;
    assign last_xfer = send_xfer && sh_last;
    assign next_word = enable && !fifo_empty;

    fifo_byte_streamer_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (state_q == ST_LOAD),
        .data_i  (fifo_data),
        .shift_i (send_xfer),
        .byte_o  (sh_byte),
        .last_o  (sh_last)
    );

`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
    localparam int FCW = $clog2(FRAME_WORDS) + 1;

    logic [7:0]     csum_q, csum_d;
    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           csum_xfer;

    assign csum_xfer  = (state_q == ST_CSUM) && tx_ready;
    assign frame_done = (fcnt_q == FCW'(FRAME_WORDS - 1));

    always_comb begin
        csum_d = csum_q;
        fcnt_d = fcnt_q;
        if (send_xfer) begin
            csum_d = csum_q ^ sh_byte;
        end else if (csum_xfer) begin
            csum_d = '0;
        end
        if (last_xfer) begin
            fcnt_d = fcnt_q + 1'b1;
        end else if (csum_xfer) begin
            fcnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            csum_q <= '0;
            fcnt_q <= '0;
        end else begin
            csum_q <= csum_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    assign frame_done = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        case (state_q)
            ST_IDLE: begin
                if (next_word) state_d = ST_POP;
            end
            ST_POP:  state_d = ST_LOAD;
            ST_LOAD: state_d = ST_SEND;
            ST_SEND: begin
                if (last_xfer) begin
                    wc_d = wc_q + 1'b1;
                    if (frame_done) begin
`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
                        state_d = ST_CSUM;
`endif
                    end else if (next_word) begin
                        state_d = ST_POP;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_ready) state_d = next_word ? ST_POP : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
        end
    end

    assign fifo_rd_cs = (state_q == ST_POP);
    assign fifo_rd_en = (state_q == ST_POP);
    assign busy       = (state_q != ST_IDLE);
    assign word_count = wc_q;

    // Output byte is zero whenever no byte is being offered.
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        if (state_q == ST_SEND) begin
            tx_valid = 1'b1;
            tx_data  = sh_byte;
        end
`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
        if (state_q == ST_CSUM) begin
            tx_valid = 1'b1;
            tx_data  = csum_q;
        end
`endif
    end

endmodule

// File: tb/tb_fifo_byte_streamer.sv
// Bench for fifo_byte_streamer: FIFO model, expected byte stream built from pushed words,
// one per-cycle compare process plus directed literal checks.
module tb_fifo_byte_streamer;

    localparam int WIDTH = 32;
    localparam int FW    = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd_cs, fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic [15:0] word_count;

    always #5 clk = ~clk;

    fifo_byte_streamer #(
        .WIDTH       (WIDTH),
        .FRAME_WORDS (FW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_cs (fifo_rd_cs),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .word_count (word_count)
    );

    logic [31:0] mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);

    logic [7:0]  exp_dat  [256];
    logic        exp_last [256];
    logic [7:0]  xfer_dat [256];
    int          xfer_cyc [256];
    int          exp_wr = 0;
    int          exp_rd = 0;
    logic [15:0] wc_model = '0;
    logic [7:0]  mdl_csum = '0;
    int          mdl_fw = 0;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tot_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    endtask

    task automatic push(input logic [31:0] w);
        logic [7:0] b;
        mem[wr_ptr % 64] = w;
        wr_ptr++;
        for (int i = 0; i < 4; i++) begin
            b = w[31 - 8*i -: 8];
            exp_dat[exp_wr]  = b;
            exp_last[exp_wr] = (i == 3);
            exp_wr++;
            mdl_csum ^= b;
        end
        mdl_fw++;
`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
        if (mdl_fw == FW) begin
            exp_dat[exp_wr]  = mdl_csum;
            exp_last[exp_wr] = 1'b0;
            exp_wr++;
            mdl_csum = '0;
            mdl_fw   = 0;
        end
`endif
    endtask

    // Per-cycle compare against the expected stream; also serves FIFO read data.
    task automatic monitor();
        int         cyc = 0;
        logic       pend;
        logic       prev_stall = 1'b0;
        logic [7:0] prev_dat = '0;
        forever begin
            @(negedge clk);
            cyc++;
            pend = 1'b0;
            if (rst) begin
                wc_model   = '0;
                prev_stall = 1'b0;
            end else begin
                chk("word_count", word_count, wc_model);
                if (prev_stall) begin
                    chk("hold_valid", tx_valid, 1);
                    chk("hold_data", tx_data, prev_dat);
                end
                if (tx_valid) chk("busy_when_valid", busy, 1);
                if (fifo_rd_cs && fifo_rd_en) begin
                    chk("pop_when_nonempty", fifo_empty, 0);
                    pend = !fifo_empty;
                end
                if (tx_valid && tx_ready) begin
                    chk("stream_byte_expected", exp_rd < exp_wr, 1);
                    if (exp_rd < exp_wr) begin
                        chk("tx_data", tx_data, exp_dat[exp_rd]);
                        xfer_dat[exp_rd] = tx_data;
                        xfer_cyc[exp_rd] = cyc;
                        if (exp_last[exp_rd]) wc_model++;
                        exp_rd++;
                    end
                end
                prev_stall = tx_valid && !tx_ready;
                prev_dat   = tx_data;
            end
            @(posedge clk);
            if (pend) begin
                fifo_data = mem[rd_ptr % 64];
                rd_ptr++;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm, input int maxc);
        int n = 0;
        while (!(exp_rd == exp_wr && !busy && rd_ptr == wr_ptr) && n < maxc) begin
            step();
            n++;
        end
        chk(nm, (exp_rd == exp_wr && !busy && rd_ptr == wr_ptr), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mdl_csum = '0;
        mdl_fw   = 0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not end");
        $fatal(1);
    end

    initial begin
        int base;
        int rd0;
        int n;
        fork
            monitor();
        join_none

        // Test 1: reset with a word waiting and enable high
        enable   = 1'b1;
        tx_ready = 1'b1;
        push(32'hA1B2C3D4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_rd_en", fifo_rd_en, 0);
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_word_count", word_count, 0);
        end
        rst = 1'b0;

        // Test 2: latency and byte order
        step();
        chk("t2_pop_cycle", fifo_rd_en, 1);
        chk("t2_busy", busy, 1);
        step();
        chk("t2_load_no_pop", fifo_rd_en, 0);
        chk("t2_load_no_valid", tx_valid, 0);
        step();
        chk("t2_b0_valid", tx_valid, 1);
        chk("t2_b0", tx_data, 8'hA1);
        step();
        chk("t2_b1", tx_data, 8'hB2);
        step();
        chk("t2_b2", tx_data, 8'hC3);
        step();
        chk("t2_b3", tx_data, 8'hD4);
        step();
        chk("t2_done_valid", tx_valid, 0);
        chk("t2_word_count", word_count, 1);
        chk("t2_idle", busy, 0);
        chk("t2_pops", rd_ptr, 1);

        // Test 3: stall on the second byte
        do_reset();
        push(32'hA1B2C3D4);
        n = 0;
        while (!(tx_valid && tx_data == 8'hB2) && n < 20) begin
            step();
            n++;
        end
        chk("t3_reach_b2", tx_valid && tx_data == 8'hB2, 1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_stall_valid", tx_valid, 1);
            chk("t3_stall_data", tx_data, 8'hB2);
            chk("t3_stall_no_pop", fifo_rd_en, 0);
        end
        tx_ready = 1'b1;
        drain("t3_drain", 100);
        chk("t3_word_count", word_count, 1);
        chk("t3_pops", rd_ptr, wr_ptr);

        // Test 4: three back-to-back words
        do_reset();
        base = exp_rd;
        rd0  = rd_ptr;
        push(32'h01234567);
        push(32'h89ABCDEF);
        push(32'hFEDCBA98);
        drain("t4_drain", 200);
        chk("t4_word_count", word_count, 3);
        chk("t4_pops", rd_ptr - rd0, 3);
        chk("t4_gap_1", xfer_cyc[base+4] - xfer_cyc[base+3], 3);
        chk("t4_gap_2", xfer_cyc[base+8] - xfer_cyc[base+7], 3);
        chk("t4_last_byte", xfer_dat[base+11], 8'h98);

        // Test 5: enable dropped after the first byte
        do_reset();
        rd0 = rd_ptr;
        push(32'h11223344);
        push(32'h55667788);
        n = 0;
        while (!tx_valid && n < 20) begin
            step();
            n++;
        end
        chk("t5_first_byte", tx_data, 8'h11);
        step();
        enable = 1'b0;
        repeat (15) step();
        chk("t5_word_done", word_count, 1);
        chk("t5_idle", busy, 0);
        chk("t5_one_pop", rd_ptr - rd0, 1);
        chk("t5_no_valid", tx_valid, 0);
        enable = 1'b1;
        drain("t5_drain", 100);
        chk("t5_word_count", word_count, 2);

`ifdef FIFO_BYTE_STREAMER_CHECKSUM_EN
        // Test 6: checksum frames
        do_reset();
        base = exp_rd;
        for (int i = 0; i < 4; i++) push(32'h01020304);
        for (int i = 0; i < 4; i++) push(32'h000000FF);
        for (int i = 0; i < 3; i++) push(32'h00000000);
        push(32'h00000011);
        drain("t6_drain", 400);
        chk("t6_first", xfer_dat[base], 8'h01);
        chk("t6_csum_1", xfer_dat[base+16], 8'h00);
        chk("t6_csum_2", xfer_dat[base+33], 8'h00);
        chk("t6_csum_3", xfer_dat[base+50], 8'h11);
        chk("t6_word_count", word_count, 12);
`endif

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
